// File: rtl/sync_fifo_param_pkg.sv
// sync_fifo_param_pkg: depth derivation and read-mode constants shared by the FIFO files.
package sync_fifo_param_pkg;
  localparam int MODE_STD  = 0;
  localparam int MODE_FWFT = 1;
  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction
endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: simple dual-port RAM, synchronous write, registered read with read-enable.
module sync_fifo_ram
  import sync_fifo_param_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [fifo_depth(ADDR_W)];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  // Only the read register is reset; the array stays reset-free so it maps onto RAM.
  always_ff @(posedge clk or posedge rst)
    if (rst) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with optional first-word-fall-through stage,
// fill level, almost flags, sticky overflow/underflow and synchronous flush.
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int FWFT     = 1,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr_enable,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_enable,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);
  localparam int DEPTH = fifo_depth(ADDR_W);
  logic [ADDR_W:0] wptr, rptr, count;
  logic wr_acc, ram_rd, mem_empty;
  assign count       = wptr - rptr;
  assign full        = count == (ADDR_W+1)'(DEPTH);
  assign mem_empty   = count == '0;
  assign wr_acc      = wr_enable & ~full & ~flush;
  assign almost_full  = int'(level) >= AF_LEVEL;
  assign almost_empty = int'(level) <= AE_LEVEL;
  // ram_rd advances the read pointer: a pop in standard mode, a prefetch in FWFT mode.
  if (FWFT == MODE_FWFT) begin : g_fwft
    logic valid;
    assign empty  = ~valid;
    assign ram_rd = ~flush & ~mem_empty & (~valid | rd_enable);
    assign level  = count + {{ADDR_W{1'b0}}, valid};
    always_ff @(posedge clk or posedge reset)
      if (reset) valid <= 1'b0;
      else valid <= ~flush & (ram_rd | (valid & ~rd_enable));
  end else begin : g_std
    assign empty  = mem_empty;
    assign ram_rd = ~flush & ~mem_empty & rd_enable;
    assign level  = count;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      rptr      <= wptr;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wptr      <= wr_acc ? wptr + (ADDR_W+1)'(1) : wptr;
      rptr      <= ram_rd ? rptr + (ADDR_W+1)'(1) : rptr;
      overflow  <= overflow | (wr_enable & full);
      underflow <= underflow | (rd_enable & empty);
    end
  sync_fifo_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .rst     (reset),
    .wr_en   (wr_acc),
    .wr_addr (wptr[ADDR_W-1:0]),
    .wr_data (wr_data),
    .rd_en   (ram_rd),
    .rd_addr (rptr[ADDR_W-1:0]),
    .rd_data (rd_data)
  );
endmodule
